// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: pop request, synced write pointer, status.
// Latency: none, this is wiring only.
// Backpressure: rd_en is qualified by empty inside the controller.
interface fifo_rd_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              rd_en;
    logic [ADDR_W:0]   wptr_gray_sync;
    logic              underflow_clr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [ADDR_W:0]   rptr_gray;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_level;
    logic              underflow;

    // Consumer side: issues reads, observes status.
    modport master (
        output rd_en, wptr_gray_sync, underflow_clr,
        input  rd_addr, rd_valid, rptr_gray, empty, almost_empty, rd_level, underflow
    );

    // Controller side.
    modport slave (
        input  rd_en, wptr_gray_sync, underflow_clr,
        output rd_addr, rd_valid, rptr_gray, empty, almost_empty, rd_level, underflow
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read pointer controller of the async FIFO, entirely in the read clock domain.
// Latency: pointer and status update at the same edge; read data valid 1 cycle after a fire.
// Backpressure: reads while empty are dropped and flagged as a sticky underflow.
module fifo_rd_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int AE_THRESH = 2
) (
    input  logic          clk,
    input  logic          rst,
    fifo_rd_ctrl_if.slave bus
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rgray_q;
    logic          empty_q;
    logic          ae_q;
    logic [PW-1:0] level_q;
    logic          rd_valid_q;
    logic          underflow_q;

    logic          rd_fire;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;

    // Next pointer values; a read only fires against the registered empty flag.
    always_comb begin
        rd_fire    = bus.rd_en & ~empty_q;
        rbin_next  = rbin + {{ADDR_W{1'b0}}, rd_fire};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
    end

    // Decode the synchronized Gray write pointer and compute occupancy after this read.
    always_comb begin
        wbin[PW-1] = bus.wptr_gray_sync[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ bus.wptr_gray_sync[i];
        end
        level_next = wbin - rbin_next;
    end

    // Pointer and status registers; empty compares Gray codes so it never sees a torn value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbin       <= '0;
            rgray_q    <= '0;
            empty_q    <= 1'b1;
            ae_q       <= 1'b1;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rbin       <= rbin_next;
            rgray_q    <= rgray_next;
            empty_q    <= (rgray_next == bus.wptr_gray_sync);
            ae_q       <= (level_next <= AE_T);
            level_q    <= level_next;
            rd_valid_q <= rd_fire;
        end
    end

    // Sticky underflow; a new underflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else if (bus.rd_en && empty_q) begin
            underflow_q <= 1'b1;
        end else if (bus.underflow_clr) begin
            underflow_q <= 1'b0;
        end
    end

    // Outputs come straight from registers; rd_addr has no path from the inputs.
    always_comb begin
        bus.rd_addr      = rbin[ADDR_W-1:0];
        bus.rptr_gray    = rgray_q;
        bus.empty        = empty_q;
        bus.almost_empty = ae_q;
        bus.rd_level     = level_q;
        bus.rd_valid     = rd_valid_q;
        bus.underflow    = underflow_q;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer controller for the async FIFO; lives entirely in the read clock domain.
- Consumes the write pointer (Gray, ADDR_W+1 bits) after it has passed through the 2-flop synchronizer.
- Maintains the binary and Gray read pointers and drives the FIFO RAM read address and read-valid.
- Generates empty, almost_empty, occupancy level and a sticky underflow flag.
- Its Gray read pointer output feeds the synchronizer toward the write domain.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH.

Ports:
clk  input  1  read-domain clock, rising edge.
rst  input  1  asynchronous reset, active-high.
rd_en  input  1  read request.
wptr_gray_sync  input  ADDR_W+1  synchronized write pointer, Gray coded.
underflow_clr  input  1  clears the underflow flag.
rd_addr  output  ADDR_W  RAM read address.
rd_valid  output  1  RAM read data valid this cycle.
rptr_gray  output  ADDR_W+1  registered Gray read pointer, to synchronizer.
empty  output  1  FIFO empty, registered.
almost_empty  output  1  level <= AE_THRESH, registered.
rd_level  output  ADDR_W+1  entries available, registered.
underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (async, rst=1): rbin=0, rptr_gray=0, empty=1, almost_empty=1, rd_level=0, rd_valid=0, underflow=0. Reset applied mid-read aborts immediately; no partial state survives.
- rd_fire = rd_en & ~empty, using the registered empty.
- rbin_next = rbin + rd_fire, modulo 2**(ADDR_W+1); wraps from all-ones to 0 with no special case.
- rgray_next = (rbin_next >> 1) ^ rbin_next.
- All of the following update on every posedge clk:
  - rbin <= rbin_next; rptr_gray <= rgray_next.
  - empty <= (rgray_next == wptr_gray_sync).
  - wbin = gray-to-binary of wptr_gray_sync (MSB passes through; each lower bit = XOR of all higher Gray bits).
  - rd_level <= (wbin - rbin_next), modulo 2**(ADDR_W+1).
  - almost_empty <= (level_next <= AE_THRESH).
  - rd_valid <= rd_fire.
- rd_addr = rbin[ADDR_W-1:0], driven directly from the register with no combinational path from inputs. The RAM has a 1-cycle synchronous read, so data for address A is valid in the cycle after rd_fire, together with rd_valid.
- Latency:
  - A change on wptr_gray_sync is reflected on empty, rd_level and almost_empty after 1 clk edge.
  - A read is reflected on those outputs at the same edge at which the pointer advances.
- Read while empty (rd_en=1, empty=1):
  - Pointer holds, rd_valid=0.
  - underflow <= 1.
  - If underflow_clr=1 in the same cycle, set wins.
- underflow_clr alone: underflow <= 0 next edge.
- Empty is pessimistic by design: a newly synchronized write is seen late, and that is acceptable. wptr_gray_sync changes by at most 1 Gray step per write-domain clock.
- Full detection is not in this block.

Test Plan:
- Reset: rst=1 with random inputs -> empty=1, almost_empty=1, rd_level=0, rptr_gray=5'b00000, rd_valid=0, underflow=0, asynchronously before any clk edge.
- Fill visibility: wptr_gray_sync=5'b00010 (bin 3), rd_en=0 -> after 1 edge: empty=0, rd_level=3, almost_empty=0, rd_addr=0.
- Drain: continuing from fill, rd_en=1 for 3 cycles:
  - rd_addr 0, 1, 2 on successive cycles; rd_valid high in the 3 cycles after each fire.
  - rd_level 2, 1, 0; almost_empty=1 from level 2.
  - After the 3rd fire: empty=1, rptr_gray=5'b00010; a 4th rd_en cycle does not move the pointer.
- Underflow: while empty, rd_en=1 -> underflow=1, rd_valid=0, rd_addr unchanged.
  - rd_en=1 with underflow_clr=1 in the same cycle -> underflow stays 1.
  - underflow_clr=1 alone -> underflow=0.
- Wrap: step wptr_gray_sync through Gray 0..31 then 0, reading continuously.
  - rbin passes 15->16: rd_addr 15->0, rptr_gray 5'b01000->5'b11000.
  - rbin passes 31->0: rptr_gray 5'b10000->5'b00000.
  - empty=1 exactly when the read pointer catches up; rd_level never exceeds 16.
- Reset mid-operation: rd_level=5 and rd_en=1, assert rst for 1 cycle -> all outputs return to their reset values immediately. After release with wptr_gray_sync=5'b00111 (bin 5): rd_level=5, rd_addr=0.
